// File: rtl/hex_disp_scheduler.sv
// hex_disp_scheduler: picks one of NUM_SRC 32-bit debug sources for the
// 8-digit hex display. A debounced push-button or a periodic auto-rotation
// advances the selection; freeze holds the shown value and selection.
// Optional feature macro: HEXSCHED_ZERO_BLANK_EN (leading-zero blank mask).
module hex_disp_scheduler #(
   parameter int NUM_SRC      = 4,
   parameter int SEL_W        = 2,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int ROTATE_CYC   = 50000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [32*NUM_SRC-1:0]  src_data,
   input  logic                   btn_next,
   input  logic                   auto_en,
   input  logic                   freeze,
   output logic [31:0]            disp_value,
   output logic [SEL_W-1:0]       disp_sel,
   output logic                   disp_valid,
   output logic [7:0]             blank_mask
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
   localparam int ROT_W = $clog2(ROTATE_CYC + 1);

   typedef enum logic [1:0] {ST_SWITCH, ST_LIVE, ST_HOLD} state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync2_q;
   logic               db_level_q, db_level_d, db_prev_q;
   logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
   logic [ROT_W-1:0]   rot_cnt_q, rot_cnt_d;
   logic [31:0]        value_q, value_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               valid_q, valid_d;
   logic               adv_btn, adv_rot, advance, load;
   logic [31:0]        src_sel;

   // Two-flop synchronizer for the asynchronous push-button.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous here, so it lives inside the clocked branch
      // and is only seen on an edge; all state uses non-blocking assignments.
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_next;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing cycles.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      db_level_d = db_level_q;
      db_cnt_d   = '0;
      if (sync2_q != db_level_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1))
            db_level_d = sync2_q;
         else
            db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Debounce state registers and previous level for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_level_q <= 1'b0;
         db_prev_q  <= 1'b0;
         db_cnt_q   <= '0;
      end else begin
         db_level_q <= db_level_d;
         db_prev_q  <= db_level_q;
         db_cnt_q   <= db_cnt_d;
      end
   end

   assign adv_btn = db_level_q & ~db_prev_q;
   assign adv_rot = (state_q == ST_LIVE) && auto_en &&
                    (rot_cnt_q == ROT_W'(ROTATE_CYC - 1));
   assign advance = adv_btn | adv_rot;
   assign src_sel = src_data[32*sel_q +: 32];

   // Rotate counter runs only while LIVE, auto-rotating and not advancing.
   always_comb begin
      rot_cnt_d = '0;
      if (state_q == ST_LIVE && auto_en && !freeze && !advance)
         rot_cnt_d = rot_cnt_q + 1'b1;
   end

   // Next-state and datapath decisions for the display FSM.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      load    = 1'b0;
      case (state_q)
         ST_SWITCH: begin
            load    = 1'b1;
            valid_d = 1'b1;
            state_d = ST_LIVE;
         end
         ST_LIVE: begin
            valid_d = 1'b1;
            if (freeze) begin
               state_d = ST_HOLD;
            end else begin
               load = 1'b1;
               if (advance) begin
                  sel_d   = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;
                  valid_d = 1'b0;
                  state_d = ST_SWITCH;
               end
            end
         end
         ST_HOLD: begin
            valid_d = 1'b1;
            if (!freeze) state_d = ST_LIVE;
         end
         default: state_d = ST_SWITCH;
      endcase
      value_d = load ? src_sel : value_q;
   end

   // FSM and display registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_SWITCH;
         value_q   <= '0;
         sel_q     <= '0;
         valid_q   <= 1'b0;
         rot_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         rot_cnt_q <= rot_cnt_d;
      end
   end

`ifdef HEXSCHED_ZERO_BLANK_EN
   logic [7:0] blank_q, blank_d;

   // Leading-zero blanking, recomputed whenever a new value is loaded.
   always_comb begin
      blank_d = blank_q;
      if (load) begin
         blank_d = '0;
         for (int i = 1; i < 8; i++)
            blank_d[i] = ((value_d >> (4 * i)) == 32'd0);
      end
   end

   // Blank mask register, kept in step with disp_value.
   always_ff @(posedge clk) begin
      if (rst) blank_q <= '0;
      else     blank_q <= blank_d;
   end

   assign blank_mask = blank_q;
`else
   assign blank_mask = 8'h00;
`endif

   assign disp_value = value_q;
   assign disp_sel   = sel_q;
   assign disp_valid = valid_q;

endmodule
